// File: rtl/lc3_memory_io_if.sv
// Controller-side strobes, shared bus and character-device handshakes of the LC-3 memory block.
// The master is the controller/environment and the slave is the memory subsystem.
interface lc3_memory_io_if;
  logic [15:0] bus_in;
  logic        ldMAR;
  logic        ldMDR;
  logic        selMDR;
  logic        memWE;
  logic        enaMDR;
  logic [15:0] mdr_out;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic        kbd_ready;
  logic [7:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;

  modport master (
    output bus_in, ldMAR, ldMDR, selMDR, memWE, enaMDR,
    output kbd_data, kbd_valid, dsp_ready,
    input  mdr_out, kbd_ready, dsp_data, dsp_valid
  );

  modport slave (
    input  bus_in, ldMAR, ldMDR, selMDR, memWE, enaMDR,
    input  kbd_data, kbd_valid, dsp_ready,
    output mdr_out, kbd_ready, dsp_data, dsp_valid
  );
endinterface

// File: rtl/lc3_memory_io.sv
// LC-3 memory subsystem: MAR/MDR, word-addressed RAM and memory-mapped keyboard/display registers.
// Every read or write is decoded from the MAR value held before the current edge.
module lc3_memory_io #(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  lc3_memory_io_if.slave io
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] IO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR    = 16'hFE00;
  localparam logic [15:0] KBDR    = 16'hFE02;
  localparam logic [15:0] DSR     = 16'hFE04;
  localparam logic [15:0] DDR     = 16'hFE06;

  logic [15:0]       mar;
  logic [15:0]       mdr;
  logic [15:0]       read_data;
  logic [15:0]       ram [DEPTH];
  logic              kbd_full;
  logic [7:0]        kbd_char;
  logic              dsp_valid;
  logic [7:0]        dsp_data;
  logic              is_io;
  logic [ADDR_W-1:0] ram_addr;
  logic              kbd_take;
  logic              kbdr_read;
  logic              ddr_write;

  assign is_io     = (mar >= IO_BASE);
  assign ram_addr  = mar[ADDR_W-1:0];
  assign kbd_take  = io.kbd_valid & ~kbd_full;
  assign kbdr_read = io.ldMDR & io.selMDR & (mar == KBDR);
  assign ddr_write = io.memWE & (mar == DDR);

  // Upper MAR bits are ignored below the I/O page, so RAM addresses alias.
  always_comb begin
    read_data = 16'h0000;
    if (!is_io) begin
      read_data = ram[ram_addr];
    end else begin
      case (mar)
        KBSR:    read_data = {kbd_full, 15'b0};
        KBDR:    read_data = {8'b0, kbd_char};
        DSR:     read_data = {~dsp_valid, 15'b0};
        default: read_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (io.memWE && !is_io) begin
      ram[ram_addr] <= mdr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar <= 16'h0000;
      mdr <= 16'h0000;
    end else begin
      if (io.ldMAR) begin
        mar <= io.bus_in;
      end
      if (io.ldMDR) begin
        mdr <= io.selMDR ? read_data : io.bus_in;
      end
    end
  end

  // Capture and KBDR read are mutually exclusive: capture needs kbd_full=0, the read only matters when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_full <= 1'b0;
      kbd_char <= 8'h00;
    end else if (kbd_take) begin
      kbd_full <= 1'b1;
      kbd_char <= io.kbd_data;
    end else if (kbdr_read) begin
      kbd_full <= 1'b0;
    end
  end

  // A DDR write is only accepted while nothing is pending, even in the handshake-completion cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
    end else if (dsp_valid) begin
      if (io.dsp_ready) begin
        dsp_valid <= 1'b0;
      end
    end else if (ddr_write) begin
      dsp_valid <= 1'b1;
      dsp_data  <= mdr[7:0];
    end
  end

  assign io.mdr_out   = io.enaMDR ? mdr : 16'h0000;
  assign io.kbd_ready = ~kbd_full;
  assign io.dsp_valid = dsp_valid;
  assign io.dsp_data  = dsp_data;

endmodule
